// File: rtl/mem_access_pkg.sv
// mem_access_pkg
//   Shared definitions for the data-RAM load/store front end:
//   - request size encodings (SIZE_BYTE / SIZE_HALF / SIZE_WORD; 2'b11 is illegal)
//   - FSM state enumeration
//   - is_misaligned(): alignment / legality check for an incoming request
package mem_access_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  // A misaligned or illegal request takes the same RESP state as a normal
  // completion; only the registered error flag distinguishes the two.
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_READ,
    ST_MERGE,
    ST_WRITE,
    ST_RESP
  } state_t;

  // Halves must sit on an even offset, words on offset 0; size 11 is illegal.
  function automatic logic is_misaligned(input logic [1:0] size,
                                         input logic [1:0] offset);
    logic bad;
    case (size)
      SIZE_BYTE: bad = 1'b0;
      SIZE_HALF: bad = offset[0];
      SIZE_WORD: bad = (offset != 2'b00);
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// byte_lane_merge
//   Purely combinational byte-lane logic for a 4-lane little-endian word.
//   Ports:
//     word       in  dataWidth  word read from RAM
//     offset     in  2          byte offset within the word
//     size       in  2          SIZE_BYTE / SIZE_HALF / SIZE_WORD
//     sext       in  1          sign-extend the extracted load value
//     wdata      in  dataWidth  right-aligned store data
//     loadData   out dataWidth  extracted and extended load value
//     mergedWord out dataWidth  word with the target lane(s) replaced by wdata
//   Only dataWidth = 32 is meaningful; the lane count is fixed at 4.
module byte_lane_merge
  import mem_access_pkg::*;
#(
  parameter int dataWidth = 32
) (
  input  logic [dataWidth-1:0] word,
  input  logic [1:0]           offset,
  input  logic [1:0]           size,
  input  logic                 sext,
  input  logic [dataWidth-1:0] wdata,
  output logic [dataWidth-1:0] loadData,
  output logic [dataWidth-1:0] mergedWord
);

  function automatic logic [dataWidth-1:0] ext_byte(input logic [7:0] b,
                                                    input logic s);
    return {{(dataWidth-8){s & b[7]}}, b};
  endfunction

  function automatic logic [dataWidth-1:0] ext_half(input logic [15:0] h,
                                                    input logic s);
    return {{(dataWidth-16){s & h[15]}}, h};
  endfunction

  logic [7:0]           laneByte;
  logic [15:0]          laneHalf;
  logic [4:0]           shamt;
  logic [dataWidth-1:0] laneMask;

  assign shamt = {offset, 3'b000};

  always_comb begin
    case (offset)
      2'd0:    laneByte = word[7:0];
      2'd1:    laneByte = word[15:8];
      2'd2:    laneByte = word[23:16];
      default: laneByte = word[31:24];
    endcase
    // Only even offsets reach here for halves; offset[1] picks the upper pair.
    laneHalf = offset[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (size)
      SIZE_BYTE: loadData = ext_byte(laneByte, sext);
      SIZE_HALF: loadData = ext_half(laneHalf, sext);
      default:   loadData = word;
    endcase
  end

  always_comb begin
    case (size)
      SIZE_BYTE: laneMask = {{(dataWidth-8){1'b0}}, 8'hFF} << shamt;
      SIZE_HALF: laneMask = {{(dataWidth-16){1'b0}}, 16'hFFFF} << shamt;
      default:   laneMask = '1;
    endcase
    mergedWord = (word & ~laneMask) | ((wdata << shamt) & laneMask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Load/store front end for the core's data RAM (one-cycle registered read).
//   One request outstanding at a time; sub-word stores are read-modify-write.
//   Ports:
//     clk, reset                  clock, synchronous active-high reset
//     reqValid/reqReady           request handshake (accepted when both high)
//     reqWrite, reqSize,
//     reqSigned, reqAddr, reqWdata  request fields (store data right-aligned)
//     respValid                   one-cycle response pulse
//     respRdata, respError        load result (0 for stores/errors), error flag
//     ramReadAddress,
//     ramWriteAddress             RAM word address (always the latched one)
//     ramWrite, ramIn             RAM write strobe and data
//     ramOut                      RAM read data, valid the cycle after address
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int dataWidth = 32,
  parameter int multWidth = 4,
  parameter int addrWidth = multWidth + 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 reqValid,
  output logic                 reqReady,
  input  logic                 reqWrite,
  input  logic [1:0]           reqSize,
  input  logic                 reqSigned,
  input  logic [addrWidth-1:0] reqAddr,
  input  logic [dataWidth-1:0] reqWdata,
  output logic                 respValid,
  output logic [dataWidth-1:0] respRdata,
  output logic                 respError,
  output logic [multWidth-1:0] ramReadAddress,
  output logic [multWidth-1:0] ramWriteAddress,
  output logic                 ramWrite,
  output logic [dataWidth-1:0] ramIn,
  input  logic [dataWidth-1:0] ramOut
);

  state_t               state;
  logic                 write_p0;
  logic [1:0]           size_p0;
  logic                 sext_p0;
  logic [multWidth-1:0] wordAddr_p0;
  logic [1:0]           offset_p0;
  logic [dataWidth-1:0] wdata_p0;

  logic [dataWidth-1:0] loadData;
  logic [dataWidth-1:0] mergedWord;

  // ramOut is only meaningful in MERGE, one cycle after READ presented the address.
  byte_lane_merge #(
    .dataWidth(dataWidth)
  ) u_lanes (
    .word      (ramOut),
    .offset    (offset_p0),
    .size      (size_p0),
    .sext      (sext_p0),
    .wdata     (wdata_p0),
    .loadData  (loadData),
    .mergedWord(mergedWord)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      respValid   <= 1'b0;
      respRdata   <= '0;
      respError   <= 1'b0;
      write_p0    <= 1'b0;
      size_p0     <= 2'b00;
      sext_p0     <= 1'b0;
      wordAddr_p0 <= '0;
      offset_p0   <= 2'b00;
      wdata_p0    <= '0;
    end else begin
      respValid <= 1'b0;
      respError <= 1'b0;
      respRdata <= '0;
      case (state)
        // Stage 0: accept and latch the request
        ST_IDLE: begin
          if (reqValid) begin
            write_p0    <= reqWrite;
            size_p0     <= reqSize;
            sext_p0     <= reqSigned;
            wordAddr_p0 <= reqAddr[addrWidth-1:2];
            offset_p0   <= reqAddr[1:0];
            wdata_p0    <= reqWdata;
            if (is_misaligned(reqSize, reqAddr[1:0])) begin
              state     <= ST_RESP;
              respValid <= 1'b1;
              respError <= 1'b1;
            end else if (reqWrite && (reqSize == SIZE_WORD)) begin
              state <= ST_WRITE;
            end else begin
              state <= ST_READ;
            end
          end
        end
        // Stage 1: RAM samples the read address
        ST_READ: state <= ST_MERGE;
        // Stage 2: RAM data back; register load result or write merged word
        ST_MERGE: begin
          state     <= ST_RESP;
          respValid <= 1'b1;
          if (!write_p0) respRdata <= loadData;
        end
        ST_WRITE: begin
          state     <= ST_RESP;
          respValid <= 1'b1;
        end
        // Stage 3: response cycle
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign reqReady        = (state == ST_IDLE);
  assign ramReadAddress  = wordAddr_p0;
  assign ramWriteAddress = wordAddr_p0;
  // Gated by reset so an interrupted read-modify-write never reaches the RAM.
  assign ramWrite        = ((state == ST_WRITE) || ((state == ST_MERGE) && write_p0)) && !reset;
  assign ramIn           = (state == ST_WRITE) ? wdata_p0 : mergedWord;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit with a behavioural RAM and a
// byte-array reference model of memory contents.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        reqValid, reqReady, reqWrite, reqSigned;
  logic [1:0]  reqSize;
  logic [5:0]  reqAddr;
  logic [31:0] reqWdata;
  logic        respValid, respError;
  logic [31:0] respRdata;
  logic [3:0]  ramReadAddress, ramWriteAddress;
  logic        ramWrite;
  logic [31:0] ramIn, ramOut;

  int tests = 0;
  int fails = 0;

  mem_access_unit #(.dataWidth(32), .multWidth(4)) dut (
    .clk(clk), .reset(reset),
    .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
    .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqWdata(reqWdata),
    .respValid(respValid), .respRdata(respRdata), .respError(respError),
    .ramReadAddress(ramReadAddress), .ramWriteAddress(ramWriteAddress),
    .ramWrite(ramWrite), .ramIn(ramIn), .ramOut(ramOut)
  );

  always #5 clk = ~clk;

  // Data RAM with registered read; a preload port lets the bench seed it.
  logic [31:0] ram [0:15];
  logic        pl_en = 1'b0;
  logic [3:0]  pl_addr = '0;
  logic [31:0] pl_data = '0;
  always @(posedge clk) begin
    if (pl_en) ram[pl_addr] <= pl_data;
    else if (ramWrite) ram[ramWriteAddress] <= ramIn;
    ramOut <= ram[ramReadAddress];
  end

  // Reference memory as a plain byte array.
  logic [7:0] refm [0:63];

  function automatic logic [31:0] ref_word(input int k);
    return {refm[4*k+3], refm[4*k+2], refm[4*k+1], refm[4*k]};
  endfunction

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic exp_mis(input logic [1:0] sz, input logic [5:0] a);
    if (sz == 2'd3) return 1'b1;
    return (int'(a) % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] exp_load(input logic [5:0] a, input logic [1:0] sz,
                                           input logic sg);
    longint v = 0;
    int n = nbytes(sz);
    for (int i = 0; i < n; i++) v = v + longint'(refm[int'(a) + i]) * (longint'(1) << (8 * i));
    if (sg && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [5:0] a, input logic [1:0] sz, input logic [31:0] wd);
    for (int i = 0; i < nbytes(sz); i++) refm[int'(a) + i] = wd[8*i +: 8];
  endtask

  task automatic preload();
    logic [31:0] v;
    for (int k = 0; k < 16; k++) begin
      v = (k == 3) ? 32'h8899AABB : $urandom;
      @(negedge clk);
      pl_en = 1'b1; pl_addr = 4'(k); pl_data = v;
      for (int b = 0; b < 4; b++) refm[4*k + b] = v[8*b +: 8];
    end
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  typedef struct {
    int          rcyc;
    int          rcnt;
    logic [31:0] rdat;
    logic        rerr;
    int          wcnt;
    int          wcyc;
    logic [31:0] wdat;
    logic [3:0]  waddr;
    int          busy_bad;
    logic        rdy_after;
  } obs_t;

  // Issues one request and records what the DUT does in cycles 1..6.
  task automatic do_req(input logic w, input logic [1:0] sz, input logic sg,
                        input logic [5:0] a, input logic [31:0] wd, output obs_t o);
    int guard = 0;
    o = '{rcyc: 0, rcnt: 0, rdat: '0, rerr: 1'b0, wcnt: 0, wcyc: 0,
          wdat: '0, waddr: '0, busy_bad: 0, rdy_after: 1'b0};
    @(negedge clk);
    while (!reqReady && guard < 20) begin @(negedge clk); guard++; end
    reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqWdata = wd;
    @(posedge clk); #1;
    reqValid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      if (ramWrite) begin o.wcnt++; o.wcyc = c; o.wdat = ramIn; o.waddr = ramWriteAddress; end
      if (respValid) begin
        o.rcnt++;
        if (o.rcyc == 0) begin o.rcyc = c; o.rdat = respRdata; o.rerr = respError; end
      end
      if ((o.rcyc == 0 || c <= o.rcyc) && reqReady) o.busy_bad++;
      if (o.rcyc != 0 && c == o.rcyc + 1) o.rdy_after = reqReady;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++; if (reqReady !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", reqReady); end
    tests++; if (respValid !== 1'b0) begin fails++; $display("FAIL reset_respValid: got %b want 0", respValid); end
    tests++; if (respRdata !== 32'h0) begin fails++; $display("FAIL reset_rdata: got %h want 0", respRdata); end
    tests++; if (respError !== 1'b0) begin fails++; $display("FAIL reset_error: got %b want 0", respError); end
    tests++; if (ramWrite !== 1'b0) begin fails++; $display("FAIL reset_ramWrite: got %b want 0", ramWrite); end
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_word_load();
    obs_t o;
    preload();
    do_req(1'b0, 2'b10, 1'b0, 6'h0C, 32'h0, o);
    tests++; if (o.rdat !== 32'h8899AABB) begin fails++; $display("FAIL wload_data: got %h want 8899aabb", o.rdat); end
    tests++; if (o.rcyc !== 3 || o.rcnt !== 1) begin fails++; $display("FAIL wload_timing: cyc %0d cnt %0d want 3 1", o.rcyc, o.rcnt); end
    tests++; if (o.wcnt !== 0) begin fails++; $display("FAIL wload_nowrite: got %0d want 0", o.wcnt); end
    tests++; if (o.busy_bad !== 0 || o.rdy_after !== 1'b1) begin fails++; $display("FAIL wload_ready: busy %0d after %b want 0 1", o.busy_bad, o.rdy_after); end
  endtask

  task automatic test_subword_loads();
    obs_t o;
    logic [5:0]  ta [4] = '{6'h0D, 6'h0D, 6'h0E, 6'h0C};
    logic [1:0]  ts [4] = '{2'b00, 2'b00, 2'b01, 2'b01};
    logic        tg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] te [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h0000AABB};
    preload();
    for (int i = 0; i < 4; i++) begin
      do_req(1'b0, ts[i], tg[i], ta[i], $urandom, o);
      tests++; if (o.rdat !== te[i]) begin fails++; $display("FAIL subload_%0d: got %h want %h", i, o.rdat, te[i]); end
      tests++; if (o.rcyc !== 3 || o.rerr !== 1'b0) begin fails++; $display("FAIL subload_resp_%0d: cyc %0d err %b want 3 0", i, o.rcyc, o.rerr); end
    end
  endtask

  task automatic test_byte_store();
    obs_t o;
    preload();
    do_req(1'b1, 2'b00, 1'b0, 6'h0E, 32'hCAFE0055, o);
    ref_store(6'h0E, 2'b00, 32'hCAFE0055);
    tests++; if (o.wcnt !== 1 || o.wcyc !== 2) begin fails++; $display("FAIL bstore_wrcyc: cnt %0d cyc %0d want 1 2", o.wcnt, o.wcyc); end
    tests++; if (o.wdat !== 32'h8855AABB) begin fails++; $display("FAIL bstore_ramIn: got %h want 8855aabb", o.wdat); end
    tests++; if (o.waddr !== 4'd3) begin fails++; $display("FAIL bstore_addr: got %0d want 3", o.waddr); end
    tests++; if (o.rcyc !== 3 || o.rdat !== 32'h0) begin fails++; $display("FAIL bstore_resp: cyc %0d data %h want 3 0", o.rcyc, o.rdat); end
    do_req(1'b0, 2'b10, 1'b0, 6'h0C, 32'h0, o);
    tests++; if (o.rdat !== 32'h8855AABB) begin fails++; $display("FAIL bstore_readback: got %h want 8855aabb", o.rdat); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    preload();
    do_req(1'b0, 2'b10, 1'b0, 6'h0D, 32'h0, o);
    tests++; if (o.rcyc !== 1 || o.rerr !== 1'b1 || o.rdat !== 32'h0) begin fails++; $display("FAIL mis_wload: cyc %0d err %b data %h want 1 1 0", o.rcyc, o.rerr, o.rdat); end
    tests++; if (o.wcnt !== 0) begin fails++; $display("FAIL mis_wload_write: got %0d want 0", o.wcnt); end
    do_req(1'b1, 2'b01, 1'b0, 6'h0F, 32'h1234, o);
    tests++; if (o.rcyc !== 1 || o.rerr !== 1'b1 || o.wcnt !== 0) begin fails++; $display("FAIL mis_hstore: cyc %0d err %b wr %0d want 1 1 0", o.rcyc, o.rerr, o.wcnt); end
    do_req(1'b1, 2'b11, 1'b0, 6'h0C, 32'h1234, o);
    tests++; if (o.rcyc !== 1 || o.rerr !== 1'b1 || o.wcnt !== 0) begin fails++; $display("FAIL mis_size3: cyc %0d err %b wr %0d want 1 1 0", o.rcyc, o.rerr, o.wcnt); end
    tests++; if (o.rdy_after !== 1'b1) begin fails++; $display("FAIL mis_ready_after: got %b want 1", o.rdy_after); end
    tests++; if (ram[3] !== 32'h8899AABB) begin fails++; $display("FAIL mis_ram: got %h want 8899aabb", ram[3]); end
  endtask

  task automatic test_reset_mid_merge();
    int bad = 0;
    preload();
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b01; reqSigned = 1'b0;
    reqAddr = 6'h0C; reqWdata = 32'h00001234;
    @(posedge clk); #1;              // E0: accepted
    reqValid = 1'b0;
    @(posedge clk); #1;              // E1: now in MERGE
    reset = 1'b1;
    @(negedge clk);
    tests++; if (ramWrite !== 1'b0) begin fails++; $display("FAIL rstmid_ramWrite: got %b want 0", ramWrite); end
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    tests++; if (reqReady !== 1'b1) begin fails++; $display("FAIL rstmid_ready: got %b want 1", reqReady); end
    if (respValid) bad++;
    repeat (3) begin @(negedge clk); if (respValid) bad++; end
    tests++; if (bad !== 0) begin fails++; $display("FAIL rstmid_noresp: got %0d pulses want 0", bad); end
    tests++; if (ram[3] !== 32'h8899AABB) begin fails++; $display("FAIL rstmid_ram: got %h want 8899aabb", ram[3]); end
  endtask

  task automatic test_back_to_back();
    int acc = 0, r1 = 0, r2 = 0, nresp = 0, wc = 0, busy_bad = 0;
    logic [31:0] d2 = '0;
    preload();
    @(negedge clk);
    reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'b10; reqSigned = 1'b0;
    reqAddr = 6'h0C; reqWdata = 32'h12345678;
    @(posedge clk); #1;
    reqWrite = 1'b0; reqWdata = 32'h0;   // next request: word load, valid stays high
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (ramWrite) wc++;
      if (respValid) begin
        nresp++;
        if (r1 == 0) r1 = c;
        else begin r2 = c; d2 = respRdata; end
      end
      if (acc > 0 && c > acc && c <= acc + 3 && reqReady) busy_bad++;
      if (acc == 0 && reqReady) begin
        acc = c;
        @(posedge clk); #1;
        reqValid = 1'b0;
      end
    end
    ref_store(6'h0C, 2'b10, 32'h12345678);
    reqValid = 1'b0;
    tests++; if (acc !== 3) begin fails++; $display("FAIL b2b_accept: cycle %0d want 3", acc); end
    tests++; if (r1 !== 2 || r2 !== 6 || nresp !== 2) begin fails++; $display("FAIL b2b_resp: %0d %0d n%0d want 2 6 n2", r1, r2, nresp); end
    tests++; if (d2 !== 32'h12345678) begin fails++; $display("FAIL b2b_data: got %h want 12345678", d2); end
    tests++; if (wc !== 1 || busy_bad !== 0) begin fails++; $display("FAIL b2b_wr_busy: wr %0d busy %0d want 1 0", wc, busy_bad); end
  endtask

  task automatic test_random();
    obs_t o;
    logic w, sg, mis;
    logic [1:0] sz;
    logic [5:0] a;
    logic [31:0] wd, er;
    int ecyc;
    preload();
    for (int i = 0; i < 150; i++) begin
      w  = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 1) == 0) ? 6'($urandom_range(0, 15) * 4) : 6'($urandom_range(0, 63));
      wd = $urandom;
      mis  = exp_mis(sz, a);
      er   = (mis || w) ? 32'h0 : exp_load(a, sz, sg);
      ecyc = mis ? 1 : (w && sz == 2'b10) ? 2 : 3;
      do_req(w, sz, sg, a, wd, o);
      if (w && !mis) ref_store(a, sz, wd);
      tests++; if (o.rcyc !== ecyc || o.rcnt !== 1) begin fails++; $display("FAIL rnd_timing_%0d: cyc %0d cnt %0d want %0d 1", i, o.rcyc, o.rcnt, ecyc); end
      tests++; if (o.rdat !== er || o.rerr !== mis) begin fails++; $display("FAIL rnd_resp_%0d: data %h err %b want %h %b", i, o.rdat, o.rerr, er, mis); end
      tests++; if (o.wcnt !== ((w && !mis) ? 1 : 0)) begin fails++; $display("FAIL rnd_wcount_%0d: got %0d", i, o.wcnt); end
      if (w && !mis) begin
        tests++;
        if (o.wdat !== ref_word(int'(a[5:2])) || o.waddr !== a[5:2]) begin
          fails++; $display("FAIL rnd_wdata_%0d: got %h@%0d want %h@%0d", i, o.wdat, o.waddr, ref_word(int'(a[5:2])), a[5:2]);
        end
      end
    end
    for (int k = 0; k < 16; k++) begin
      tests++; if (ram[k] !== ref_word(k)) begin fails++; $display("FAIL rnd_final_mem_%0d: got %h want %h", k, ram[k], ref_word(k)); end
    end
  endtask

  initial begin
    reset = 1'b1; reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'b00;
    reqSigned = 1'b0; reqAddr = '0; reqWdata = '0;
    test_reset();
    test_word_load();
    test_subword_loads();
    test_byte_store();
    test_misaligned();
    test_reset_mid_merge();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
